wb_burst_fetch: RTL and testbench
=================================

WB_BURST_FETCH -- requirements
Module: wb_burst_fetch

Interface
REQ-001 SHALL have parameter ADDRESS, default 21, meaning the word-address width of wb_adr_o.
REQ-002 SHALL have parameter BURST, default 16, meaning the maximum beats per burst (power of two, 2..64).
REQ-003 SHALL have parameter RETRY_WAIT, default 4, meaning the idle cycles after wb_rty_i before reissue.
REQ-004 SHALL run from one clock and a synchronous, active-high reset; all ports and their meanings are as follows:
  wb_clk_i  in  1  sole clock, rising edge
  wb_rst_i  in  1  synchronous active-high reset
  start_i  in  1  one-cycle request to fetch a block
  base_i  in  ADDRESS  first word address, sampled with start_i
  len_i  in  12  word count, sampled with start_i
  busy_o  out  1  fetch in progress
  done_o  out  1  one-cycle pulse when the last word is acked
  err_o  out  1  sticky error flag, cleared by the next accepted start_i
  wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle/strobe
  wb_we_o  out  1  tied 0
  wb_cti_o  out  3  cycle type
  wb_bte_o  out  2  tied 00 (linear)
  wb_adr_o  out  ADDRESS  word address
  wb_sel_o  out  4  tied 1111
  wb_ack_i, wb_rty_i, wb_err_i  in  1 each  slave termination
  wb_dat_i  in  32  read data
  dat_o  out  32  FIFO head word
  valid_o  out  1  FIFO non-empty
  ready_i  in  1  consumer pop; a word pops when valid_o && ready_i

Function
REQ-005 SHALL contain a 2*BURST-deep, 32-bit first-word-fall-through FIFO; a simultaneous push and pop SHALL leave the level unchanged.
REQ-006 SHALL implement states IDLE, WAIT, BURST and BACKOFF.
REQ-007 IDLE: start_i with len_i!=0 SHALL latch base_i and len_i, clear err_o, set busy_o and go to WAIT; start_i with len_i==0 SHALL pulse done_o on the next cycle with no bus activity; start_i SHALL be ignored while busy_o=1.
REQ-008 WAIT: beats = min(BURST, remaining); SHALL go to BURST, asserting wb_cyc_o and wb_stb_o on the next cycle, only when FIFO free space >= beats.
REQ-009 BURST: wb_cti_o SHALL be 010 on every beat except the final beat, which SHALL be 111; a one-beat burst SHALL use 000.
REQ-010 Each cycle with wb_ack_i=1 SHALL push wb_dat_i into the FIFO, increment wb_adr_o by 1 (modulo 2^ADDRESS) and decrement remaining and the beat count.
REQ-011 The ack of the final beat SHALL deassert wb_cyc_o and wb_stb_o on the next cycle; the FSM SHALL then return to WAIT if remaining!=0, or else to IDLE with done_o pulsed in that cycle and busy_o cleared.
REQ-012 wb_rty_i during BURST SHALL push no data, deassert wb_cyc_o and wb_stb_o next cycle, hold for RETRY_WAIT cycles in BACKOFF, and then return to WAIT, resuming from the un-acked address with recomputed beats.
REQ-013 wb_err_i during BURST SHALL push no data, deassert wb_cyc_o and wb_stb_o next cycle, set err_o, clear busy_o, go to IDLE and not pulse done_o; words already in the FIFO SHALL remain.
REQ-014 Priority when several terminations are asserted at once SHALL be err > rty > ack.
REQ-015 wb_cyc_o SHALL equal wb_stb_o at all times; the address SHALL not change without an ack.

Reset
REQ-016 wb_rst_i SHALL force state IDLE, wb_cyc_o=0, wb_stb_o=0, wb_cti_o=000, wb_adr_o=0, busy_o=0, done_o=0, err_o=0, and FIFO empty (valid_o=0, dat_o=0), including mid-burst, with the bus released in the same cycle reset is sampled.

Verification
REQ-017 base=0, len=16, ready_i=1, slave acks every cycle -> one burst with adr 0..15, cti 010 ×15 then 111, done_o pulse, dat_o sequence equals slave data in order.
REQ-018 base=0x100, len=40, ready_i=0 -> bursts of 16 and 16, then the bus stays idle with the FIFO full (32); popping 8 words -> a third burst of 8 beats at 0x120..0x127.
REQ-019 len=1 -> a single cycle with cti=000, adr=base, one FIFO word, done_o pulse.
REQ-020 rty on the first beat of len=16 -> cyc low for RETRY_WAIT+ cycles, reissue at the same address, 16 words total, no duplicates.
REQ-021 err on beat 6 of len=16 -> cyc low next cycle, err_o=1, busy_o=0, no done_o, 5 words in the FIFO; the next start_i clears err_o.
REQ-022 wb_rst_i asserted mid-burst -> cyc/stb low in that cycle, valid_o=0, and the FSM accepts a new start_i after reset.

Source files
------------

// File: rtl/wb_burst_fetch_if.sv
// Wishbone B4 read-only bus between the burst fetcher (master) and a memory slave.
interface wb_burst_fetch_if #(
    parameter int ADDRESS = 21
);
    logic               wb_cyc_o;
    logic               wb_stb_o;
    logic               wb_we_o;
    logic [2:0]         wb_cti_o;
    logic [1:0]         wb_bte_o;
    logic [ADDRESS-1:0] wb_adr_o;
    logic [3:0]         wb_sel_o;
    logic               wb_ack_i;
    logic               wb_rty_i;
    logic               wb_err_i;
    logic [31:0]        wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o, wb_adr_o, wb_sel_o,
        input  wb_ack_i, wb_rty_i, wb_err_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o, wb_adr_o, wb_sel_o,
        output wb_ack_i, wb_rty_i, wb_err_i, wb_dat_i
    );
endinterface

// File: rtl/wb_burst_fetch.sv
// Fetches a block of words over Wishbone incrementing bursts into a first-word-fall-through
// FIFO; a burst is only issued once the FIFO can absorb all of its beats.
module wb_burst_fetch #(
    parameter int ADDRESS    = 21,
    parameter int BURST      = 16,
    parameter int RETRY_WAIT = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start_i,
    input  logic [ADDRESS-1:0] base_i,
    input  logic [11:0]        len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    wb_burst_fetch_if.master   wb,
    output logic [31:0]        dat_o,
    output logic               valid_o,
    input  logic               ready_i
);
    localparam int DEPTH = 2 * BURST;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int BW    = $clog2(BURST) + 1;
    localparam int RW    = $clog2(RETRY_WAIT + 1) + 1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST, ST_BACKOFF} state_e;

    state_e             state_q;
    logic               cyc_q, busy_q, done_q, err_q;
    logic [2:0]         cti_q;
    logic [ADDRESS-1:0] adr_q;
    logic [11:0]        rem_q;
    logic [BW-1:0]      beat_q;
    logic [RW-1:0]      bo_q;

    logic [31:0]        mem_q [DEPTH];
    logic [PW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      count_q;

    logic [BW-1:0]      beats_d;
    logic [CW-1:0]      free_d;
    logic               push, pop;

    assign beats_d = (rem_q >= 12'(BURST)) ? BW'(BURST) : BW'(rem_q);
    assign free_d  = CW'(DEPTH) - count_q;
    assign push    = cyc_q && wb.wb_ack_i && !wb.wb_rty_i && !wb.wb_err_i;
    assign valid_o = (count_q != '0);
    assign pop     = valid_o && ready_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            adr_q   <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            bo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (len_i != 12'd0) begin
                            adr_q   <= base_i;
                            rem_q   <= len_i;
                            busy_q  <= 1'b1;
                            state_q <= ST_WAIT;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (free_d >= CW'(beats_d)) begin
                        cyc_q   <= 1'b1;
                        beat_q  <= beats_d;
                        cti_q   <= (beats_d == BW'(1)) ? CTI_CLASSIC : CTI_INCR;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // Error outranks retry, which outranks ack.
                    if (wb.wb_err_i) begin
                        cyc_q   <= 1'b0;
                        cti_q   <= CTI_CLASSIC;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (wb.wb_rty_i) begin
                        cyc_q   <= 1'b0;
                        cti_q   <= CTI_CLASSIC;
                        bo_q    <= RW'(RETRY_WAIT);
                        state_q <= ST_BACKOFF;
                    end else if (wb.wb_ack_i) begin
                        adr_q  <= adr_q + ADDRESS'(1);
                        rem_q  <= rem_q - 12'd1;
                        beat_q <= beat_q - BW'(1);
                        if (beat_q == BW'(1)) begin
                            cyc_q <= 1'b0;
                            cti_q <= CTI_CLASSIC;
                            if (rem_q == 12'd1) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_WAIT;
                            end
                        end else begin
                            cti_q <= (beat_q == BW'(2)) ? CTI_END : CTI_INCR;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (bo_q <= RW'(1)) begin
                        state_q <= ST_WAIT;
                    end else begin
                        bo_q <= bo_q - RW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_q] <= wb.wb_dat_i;
    end

    // The bus is released combinationally so reset frees it in the very cycle it is sampled.
    assign wb.wb_cyc_o = cyc_q && !wb_rst_i;
    assign wb.wb_stb_o = cyc_q && !wb_rst_i;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_bte_o = 2'b00;
    assign wb.wb_sel_o = 4'hF;
    assign wb.wb_cti_o = cti_q;
    assign wb.wb_adr_o = adr_q;

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign dat_o  = valid_o ? mem_q[rd_q] : 32'd0;
endmodule

// File: tb/tb_wb_burst_fetch.sv
// Directed bench for wb_burst_fetch: a transaction-level model of the fetch (expected address,
// words outstanding, FIFO contents as a queue) is compared against the DUT every cycle.
module tb_wb_burst_fetch;
    localparam int ADDRESS    = 21;
    localparam int BURST      = 16;
    localparam int RETRY_WAIT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_i = 1'b0;
    logic [ADDRESS-1:0] base_i = '0;
    logic [11:0]        len_i = '0;
    logic               ready_i = 1'b0;
    logic               busy_o, done_o, err_o, valid_o;
    logic [31:0]        dat_o;

    wb_burst_fetch_if #(.ADDRESS(ADDRESS)) bus ();

    wb_burst_fetch #(.ADDRESS(ADDRESS), .BURST(BURST), .RETRY_WAIT(RETRY_WAIT)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .start_i  (start_i),
        .base_i   (base_i),
        .len_i    (len_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .wb       (bus.master),
        .dat_o    (dat_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Model state: values the DUT registers must hold after the most recent clock edge.
    logic [31:0]        q[$];
    logic [ADDRESS-1:0] mAdr = '0;
    int                 mRem = 0, mBeatsLeft = 0, mBurstTotal = 0, mLow = 0, stbIdx = 0;
    logic               mBusy = 1'b0, mErr = 1'b0, mDone = 1'b0;
    int                 rtyAt = -1, errAt = -1;

    logic [ADDRESS-1:0] burstStarts[$];
    int                 burstBeats[$];
    logic [2:0]         burstCti0[$];
    int                 ackCount = 0, doneCount = 0, popCount = 0;
    logic [ADDRESS-1:0] finalAdr = '0;

    function automatic logic [31:0] slaveData(input logic [ADDRESS-1:0] a);
        return {11'h5A3, a};
    endfunction

    function automatic void checkOutput(input string name, input logic [63:0] act,
                                        input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        logic sAck, sRty, sErr, accept, isFinal;
        int   expCti;
        sAck = 1'b0; sRty = 1'b0; sErr = 1'b0; isFinal = 1'b0; expCti = 0;
        if (rst) begin
            checkOutput("cyc_in_reset", bus.wb_cyc_o, 1'b0);
            checkOutput("stb_in_reset", bus.wb_stb_o, 1'b0);
            q.delete();
            mBusy = 1'b0; mErr = 1'b0; mDone = 1'b0; mAdr = '0;
            mRem = 0; mBeatsLeft = 0; mLow = 0;
        end else begin
            checkOutput("cyc_eq_stb", bus.wb_stb_o, bus.wb_cyc_o);
            checkOutput("busy", busy_o, mBusy);
            checkOutput("err", err_o, mErr);
            checkOutput("done", done_o, mDone);
            checkOutput("valid", valid_o, q.size() != 0);
            if (q.size() != 0) checkOutput("dat", dat_o, q[0]);
            else               checkOutput("dat_empty", dat_o, 32'd0);
            if (mLow > 0) begin
                checkOutput("cyc_released", bus.wb_cyc_o, 1'b0);
                mLow--;
            end
            if (!mBusy) checkOutput("bus_idle", bus.wb_cyc_o, 1'b0);
            if (done_o) doneCount++;

            if (bus.wb_cyc_o && mBusy) begin
                if (mBeatsLeft == 0) begin
                    mBurstTotal = (mRem < BURST) ? mRem : BURST;
                    mBeatsLeft  = mBurstTotal;
                    checkOutput("fifo_room", (2 * BURST - q.size()) >= mBurstTotal, 1'b1);
                    burstStarts.push_back(bus.wb_adr_o);
                    burstBeats.push_back(mBurstTotal);
                    burstCti0.push_back(bus.wb_cti_o);
                end
                isFinal = (mBeatsLeft == 1);
                expCti  = (mBurstTotal == 1) ? 0 : (isFinal ? 7 : 2);
                checkOutput("adr", bus.wb_adr_o, mAdr);
                checkOutput("cti", bus.wb_cti_o, expCti);
                checkOutput("we_bte_sel", {bus.wb_we_o, bus.wb_bte_o, bus.wb_sel_o}, 7'b0001111);
                // Fault beats also raise the lower-priority terminations.
                if (stbIdx == errAt)      begin sErr = 1'b1; sRty = 1'b1; sAck = 1'b1; end
                else if (stbIdx == rtyAt) begin sRty = 1'b1; sAck = 1'b1; end
                else                           sAck = 1'b1;
                stbIdx++;
            end

            if (valid_o && ready_i && q.size() != 0) begin
                void'(q.pop_front());
                popCount++;
            end

            accept = start_i && !mBusy;
            mDone  = 1'b0;
            if (sErr) begin
                mErr = 1'b1; mBusy = 1'b0; mRem = 0; mBeatsLeft = 0; mLow = 1;
            end else if (sRty) begin
                mBeatsLeft = 0; mLow = RETRY_WAIT;
            end else if (sAck) begin
                q.push_back(slaveData(mAdr));
                ackCount++;
                if (isFinal && mBurstTotal > 1) finalAdr = mAdr;
                mAdr = mAdr + 1'b1;
                mRem--;
                mBeatsLeft--;
                if (mBeatsLeft == 0) mLow = 1;
                if (mRem == 0) begin mBusy = 1'b0; mDone = 1'b1; end
            end
            if (accept) begin
                mErr   = 1'b0;
                stbIdx = 0;
                if (len_i != 12'd0) begin
                    mBusy = 1'b1; mRem = int'(len_i); mAdr = base_i;
                end else begin
                    mDone = 1'b1;
                end
            end
        end
        bus.wb_ack_i = sAck;
        bus.wb_rty_i = sRty;
        bus.wb_err_i = sErr;
        bus.wb_dat_i = sAck ? slaveData(bus.wb_adr_o) : 32'hDEADBEEF;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [ADDRESS-1:0] base, input logic [11:0] len);
        start_i = 1'b1; base_i = base; len_i = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while (busy_o && n < maxCycles) begin tick(); n++; end
        checkOutput("idle_timeout", busy_o, 1'b0);
        tick(2);
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        ready_i = 1'b1;
        while (valid_o && n < maxCycles) begin tick(); n++; end
        checkOutput("drain_timeout", valid_o, 1'b0);
        tick();
    endtask

    task automatic clearRecords();
        burstStarts.delete(); burstBeats.delete(); burstCti0.delete();
        ackCount = 0; doneCount = 0; popCount = 0;
    endtask

    initial begin
        bus.wb_ack_i = 1'b0; bus.wb_rty_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = '0;
        tick(3);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_done", done_o, 1'b0);
        checkOutput("rst_err", err_o, 1'b0);
        checkOutput("rst_cyc", bus.wb_cyc_o, 1'b0);
        checkOutput("rst_cti", bus.wb_cti_o, 3'b000);
        checkOutput("rst_adr", bus.wb_adr_o, 21'd0);
        checkOutput("rst_valid", valid_o, 1'b0);
        checkOutput("rst_dat", dat_o, 32'd0);
        rst = 1'b0;
        tick();

        // Single 16-beat burst streaming straight through the FIFO.
        clearRecords(); ready_i = 1'b1;
        applyStimulus(21'h0, 12'd16);
        waitIdle(100); waitDrain(50);
        checkOutput("b16_bursts", burstStarts.size(), 1);
        checkOutput("b16_start", burstStarts[0], 21'h0);
        checkOutput("b16_beats", burstBeats[0], 16);
        checkOutput("b16_final_adr", finalAdr, 21'd15);
        checkOutput("b16_done", doneCount, 1);
        checkOutput("b16_pops", popCount, 16);

        // One-word fetch uses a classic cycle.
        clearRecords();
        applyStimulus(21'h55, 12'd1);
        waitIdle(50); waitDrain(50);
        checkOutput("b1_start", burstStarts[0], 21'h55);
        checkOutput("b1_cti", burstCti0[0], 3'b000);
        checkOutput("b1_acks", ackCount, 1);
        checkOutput("b1_done", doneCount, 1);

        // Address wraps modulo 2^ADDRESS.
        clearRecords();
        applyStimulus(21'h1FFFFE, 12'd4);
        waitIdle(50); waitDrain(50);
        checkOutput("wrap_acks", ackCount, 4);
        checkOutput("wrap_pops", popCount, 4);

        // Zero length: done pulse, no bus traffic.
        clearRecords();
        applyStimulus(21'h77, 12'd0);
        tick(3);
        checkOutput("len0_done", doneCount, 1);
        checkOutput("len0_bursts", burstStarts.size(), 0);

        // FIFO back-pressure: two bursts fill it, third waits for room.
        clearRecords(); ready_i = 1'b0;
        applyStimulus(21'h100, 12'd40);
        tick(60);
        checkOutput("bp_bursts", burstStarts.size(), 2);
        checkOutput("bp_start1", burstStarts[1], 21'h110);
        checkOutput("bp_acks", ackCount, 32);
        checkOutput("bp_busy", busy_o, 1'b1);
        applyStimulus(21'h777, 12'd5);
        tick(10);
        checkOutput("bp_start_ignored", burstStarts.size(), 2);
        ready_i = 1'b1; tick(8); ready_i = 1'b0;
        waitIdle(100);
        checkOutput("bp_third_start", burstStarts[2], 21'h120);
        checkOutput("bp_third_beats", burstBeats[2], 8);
        checkOutput("bp_total_acks", ackCount, 40);
        checkOutput("bp_done", doneCount, 1);
        waitDrain(100);
        checkOutput("bp_pops", popCount, 40);

        // Retry on the first beat: backoff then reissue at the same address.
        clearRecords(); rtyAt = 0;
        applyStimulus(21'h200, 12'd16);
        waitIdle(100); waitDrain(50);
        rtyAt = -1;
        checkOutput("rty_bursts", burstStarts.size(), 2);
        checkOutput("rty_reissue", burstStarts[1], 21'h200);
        checkOutput("rty_acks", ackCount, 16);
        checkOutput("rty_pops", popCount, 16);

        // Error on beat 6 aborts without done; words already fetched stay.
        clearRecords(); errAt = 5; ready_i = 1'b0;
        applyStimulus(21'h300, 12'd16);
        waitIdle(100);
        errAt = -1;
        checkOutput("err_flag", err_o, 1'b1);
        checkOutput("err_busy", busy_o, 1'b0);
        checkOutput("err_no_done", doneCount, 0);
        checkOutput("err_acks", ackCount, 5);
        waitDrain(50);
        checkOutput("err_pops", popCount, 5);
        checkOutput("err_sticky", err_o, 1'b1);
        applyStimulus(21'h400, 12'd2);
        checkOutput("err_cleared", err_o, 1'b0);
        waitIdle(50);

        // Reset mid-burst releases the bus immediately and empties the FIFO.
        clearRecords(); ready_i = 1'b0;
        applyStimulus(21'h500, 12'd16);
        tick(5);
        checkOutput("mid_cyc", bus.wb_cyc_o, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_cyc", bus.wb_cyc_o, 1'b0);
        checkOutput("rst_mid_stb", bus.wb_stb_o, 1'b0);
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_valid", valid_o, 1'b0);
        checkOutput("rst_mid_busy", busy_o, 1'b0);
        checkOutput("rst_mid_adr", bus.wb_adr_o, 21'd0);
        clearRecords(); ready_i = 1'b1;
        applyStimulus(21'h600, 12'd3);
        waitIdle(50); waitDrain(50);
        checkOutput("post_rst_start", burstStarts[0], 21'h600);
        checkOutput("post_rst_done", doneCount, 1);
        checkOutput("post_rst_pops", popCount, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] simulation did not complete");
    end
endmodule
